// File: rtl/seq_mac_unit.sv
// Iterative shift-add multiply-accumulate unit with valid/ready handshakes.
// One multiplier bit per clock; optional persistent accumulator with overflow flag.
module seq_mac_unit #(
  parameter int A_WIDTH   = 7,
  parameter int B_WIDTH   = 4,
  parameter int ACC_WIDTH = A_WIDTH + B_WIDTH + 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [A_WIDTH-1:0]   A,
  input  logic [B_WIDTH-1:0]   B,
  input  logic                 Signed_Mode,
  input  logic                 Accumulate,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [ACC_WIDTH-1:0] Result,
  output logic                 Overflow
);

  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int CW = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(B_WIDTH - 1);
  localparam int M = ACC_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [A_WIDTH-1:0]   a_q;
  logic [B_WIDTH-1:0]   b_q;
  logic                 sgn_q;
  logic                 accm_q;
  logic [PW-1:0]        pp;
  logic [PW-1:0]        pp_nx;
  logic [PW-1:0]        a_ext;
  logic [PW-1:0]        term;
  logic [CW-1:0]        cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_nx;
  logic [ACC_WIDTH-1:0] p_ext;
  logic [ACC_WIDTH:0]   sum;
  logic                 ovf_nx;
  logic                 take;
  logic                 give;
  logic                 last;

  assign take = (state == IDLE) && In_Valid && In_Ready;
  assign give = (state == DONE) && Out_Valid && Out_Ready;
  assign last = (cnt == LAST);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    if (give) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The sign bit of B carries negative weight in two's-complement mode.
  always_comb begin
    if (sgn_q) a_ext = PW'($signed(a_q));
    else       a_ext = PW'(a_q);
    term  = a_ext << cnt;
    pp_nx = pp;
    if (b_q[cnt]) begin
      if (sgn_q && last) pp_nx = pp - term;
      else               pp_nx = pp + term;
    end
  end

  always_comb begin
    if (sgn_q) p_ext = ACC_WIDTH'($signed(pp_nx));
    else       p_ext = ACC_WIDTH'(pp_nx);
    sum    = {1'b0, acc} + {1'b0, p_ext};
    acc_nx = p_ext;
    ovf_nx = 1'b0;
    if (accm_q) begin
      acc_nx = sum[M:0];
      if (sgn_q) ovf_nx = (acc[M] == p_ext[M]) && (sum[M] != acc[M]);
      else       ovf_nx = sum[ACC_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      accm_q    <= 1'b0;
      pp        <= '0;
      cnt       <= '0;
      acc       <= '0;
      Result    <= '0;
      Overflow  <= 1'b0;
      Out_Valid <= 1'b0;
      In_Ready  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (take) begin
            a_q      <= A;
            b_q      <= B;
            sgn_q    <= Signed_Mode;
            accm_q   <= Accumulate;
            pp       <= '0;
            cnt      <= '0;
            In_Ready <= 1'b0;
          end else begin
            In_Ready <= 1'b1;
          end
        end
        BUSY: begin
          pp  <= pp_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            acc       <= acc_nx;
            Result    <= acc_nx;
            Overflow  <= ovf_nx;
            Out_Valid <= 1'b1;
          end
        end
        DONE: begin
          if (give) begin
            Out_Valid <= 1'b0;
            In_Ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
